// File: rtl/debug_mon_pkg.sv
// rtl/debug_mon_pkg.sv - shared types, jdo field positions and defaults for the debug monitor master
package debug_mon_pkg;

  localparam int AW_DEFAULT      = 16;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int TO_CNT_W        = 16;

  // jdo layout: the read flag doubles as the MSB of the write data field
  localparam int JDO_W        = 38;
  localparam int JDO_READ_BIT = 34;
  localparam int JDO_DATA_HI  = 34;
  localparam int JDO_DATA_LO  = 3;
  localparam int JDO_ADDR_LO  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mon_state_e;

endpackage

// File: rtl/debug_mon_timeout.sv
// rtl/debug_mon_timeout.sv - loadable wait-cycle counter with clear, enable and terminal-count flag
module debug_mon_timeout #(
  parameter int W     = 16,
  parameter int LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the cycle in which the LIMIT-th enabled cycle is being counted
  assign tc_o = en_i && !clr_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/debug_mon_master.sv
// rtl/debug_mon_master.sv - debug monitor Avalon-MM master: jdo strobes to single-word reads/writes
module debug_mon_master
  import debug_mon_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_no_action_ocimem_a,
  output logic [31:0]      MonDReg,
  output logic             monitor_ready,
  output logic             monitor_error,
  output logic [AW-1:0]    avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam int WAW = AW - 2;

  mon_state_e     state_q, state_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic [31:0]    mondreg_q, mondreg_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           ready_q, ready_d;
  logic           error_q, error_d;
  logic           addr_only_q, addr_only_d;
  logic           to_clr, to_en, to_tc;
  logic           busy, any_strobe;
  logic           unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_READ_BIT+1], jdo[JDO_ADDR_LO-1:0]};

  assign busy       = (state_q != ST_IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign to_en      = busy && avm_waitrequest;

  debug_mon_timeout #(
    .W     (TO_CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (to_clr),
    .en_i       (to_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .tc_o       (to_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mondreg_d   = mondreg_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    error_d     = error_q;
    addr_only_d = addr_only_q;
    to_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // An address-only load reports completion one cycle after ready drops
        if (addr_only_q) begin
          ready_d     = 1'b1;
          addr_only_d = 1'b0;
        end
        if (take_action_ocimem_a) begin
          addr_d  = jdo[AW-1:JDO_ADDR_LO];
          ready_d = 1'b0;
          error_d = 1'b0;
          if (jdo[JDO_READ_BIT]) begin
            state_d     = ST_READ;
            to_clr      = 1'b1;
            addr_only_d = 1'b0;
          end else begin
            addr_only_d = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d     = jdo[JDO_DATA_HI:JDO_DATA_LO];
          ready_d     = 1'b0;
          state_d     = ST_WRITE;
          to_clr      = 1'b1;
          addr_only_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          ready_d     = 1'b0;
          state_d     = ST_READ;
          to_clr      = 1'b1;
          addr_only_d = 1'b0;
        end
      end

      ST_READ: begin
        if (!avm_waitrequest) begin
          mondreg_d = avm_readdata;
          addr_d    = addr_q + 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end else if (to_tc) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (!avm_waitrequest) begin
          addr_d  = addr_q + 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (to_tc) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The debug slave must not issue while a bus cycle is outstanding
    if (busy && any_strobe) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mondreg_q   <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      addr_only_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mondreg_q   <= mondreg_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      addr_only_q <= addr_only_d;
    end
  end

  assign avm_read       = (state_q == ST_READ);
  assign avm_write      = (state_q == ST_WRITE);
  assign avm_address    = {addr_q, 2'b00};
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mondreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

endmodule

// File: tb/tb_debug_mon_master.sv
// tb/tb_debug_mon_master.sv - scoreboard bench for debug_mon_master with an Avalon slave model
module tb_debug_mon_master;

  localparam int AW = 16;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sb = 1'b0, sn = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [AW-1:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  always #5 clk = ~clk;

  debug_mon_master #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (sa),
    .take_action_ocimem_b    (sb),
    .take_no_action_ocimem_a (sn),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_byteenable          (avm_byteenable),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave: holds waitrequest for wait_n cycles of each command, then accepts
  int          wait_n = 0;
  logic [31:0] rdata = '0;
  int          busy_cnt = 0;
  always @(posedge clk) busy_cnt <= (avm_read || avm_write) ? busy_cnt + 1 : 0;
  assign avm_waitrequest = (avm_read || avm_write) && (busy_cnt < wait_n);
  assign avm_readdata    = rdata;

  typedef struct {bit wr; logic [15:0] addr; logic [31:0] data; int cycles;} bus_t;
  typedef struct {logic [31:0] mdr; bit err;} comp_t;
  bus_t  bus_q[$];
  comp_t comp_q[$];

  // Reference state
  logic [13:0] m_addr = '0;
  logic [31:0] m_mdr = '0;
  bit          m_err = 1'b0;

  // Bus monitor: address/data checked every strobe cycle, length checked when strobe drops
  bit act_prev = 1'b0;
  int act_cycles = 0;
  always @(negedge clk) begin
    bus_t b;
    if (avm_read && avm_write) begin
      checks++; errors++;
      $display("FAIL rd_wr_both actual=1 required=0");
    end
    if (avm_read || avm_write) begin
      if (bus_q.size() == 0) begin
        if (!act_prev) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_op actual=%0h required=none", avm_address);
        end
      end else begin
        b = bus_q[0];
        chk("bus_kind", {63'd0, avm_write}, {63'd0, b.wr});
        chk("bus_addr", {48'd0, avm_address}, {48'd0, b.addr});
        if (b.wr) chk("bus_wdata", {32'd0, avm_writedata}, {32'd0, b.data});
      end
      act_cycles <= act_cycles + 1;
    end else begin
      if (act_prev && bus_q.size() > 0) begin
        b = bus_q.pop_front();
        chk("bus_cycles", 64'(act_cycles), 64'(b.cycles));
      end
      act_cycles <= 0;
    end
    act_prev <= avm_read || avm_write;
  end

  // Completion monitor: every rising monitor_ready retires one command
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    comp_t c;
    if (monitor_ready && !rdy_prev) begin
      if (comp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        c = comp_q.pop_front();
        chk("mondreg", {32'd0, MonDReg}, {32'd0, c.mdr});
        chk("error", {63'd0, monitor_error}, {63'd0, c.err});
      end
    end
    rdy_prev <= monitor_ready;
  end

  task automatic issue(input bit a, input bit b, input bit n, input logic [37:0] j,
                       input int wn, input logic [31:0] rd, input bit inject, input bit lat);
    int  op;  // 0 none, 1 read, 2 write
    bit  aborted;
    int  cnt;
    bus_t bi;
    op = 0;
    wait_n = wn;
    rdata = rd;
    if (a) begin
      m_addr = j[15:2];
      m_err = 1'b0;
      op = j[34] ? 1 : 0;
    end else if (b) begin
      op = 2;
    end else if (n) begin
      op = 1;
    end
    if (op != 0) begin
      aborted = (wn >= TO);
      bi.wr = (op == 2);
      bi.addr = {m_addr, 2'b00};
      bi.data = j[34:3];
      bi.cycles = aborted ? TO : wn + 1;
      bus_q.push_back(bi);
      if (inject) m_err = 1'b1;
      if (aborted) begin
        m_err = 1'b1;
      end else begin
        if (op == 1) m_mdr = rd;
        m_addr = m_addr + 14'd1;
      end
    end
    comp_q.push_back('{m_mdr, m_err});

    @(posedge clk); #1;
    jdo = j; sa = a; sb = b; sn = n;
    @(posedge clk); #1;
    sa = 1'b0; sb = 1'b0; sn = 1'b0;
    if (lat) begin
      chk("lat_read_n1", {63'd0, avm_read}, 64'd1);
      chk("lat_addr_n1", {48'd0, avm_address}, {48'd0, bi.addr});
      @(posedge clk); #1;
      chk("lat_ready_n2", {63'd0, monitor_ready}, 64'd1);
    end
    if (inject && op != 0) begin
      sn = 1'b1;
      @(posedge clk); #1;
      sn = 1'b0;
    end
    cnt = 0;
    while (!monitor_ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [37:0] j;
    int r, wn;
    bit a, b, n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mondreg", {32'd0, MonDReg}, 64'd0);
    chk("rst_ready", {63'd0, monitor_ready}, 64'd0);
    chk("rst_error", {63'd0, monitor_error}, 64'd0);
    chk("rst_read", {63'd0, avm_read}, 64'd0);
    chk("rst_write", {63'd0, avm_write}, 64'd0);
    chk("rst_addr", {48'd0, avm_address}, 64'd0);
    chk("rst_wdata", {32'd0, avm_writedata}, 64'd0);
    chk("byteenable", {60'd0, avm_byteenable}, 64'hF);
    reset = 1'b0;

    // Address load + zero-wait read, with latency check
    j = '0; j[34] = 1'b1; j[15:0] = 16'h0010;
    issue(1, 0, 0, j, 0, 32'hDEADBEEF, 0, 1);
    // Write 0x12345678 with three wait cycles, then read at next word
    j = '0; j[34:3] = 32'h12345678;
    issue(0, 1, 0, j, 3, 32'h0, 0, 0);
    issue(0, 0, 1, '0, 0, 32'hCAFEF00D, 0, 0);
    // Timeout abort, then boundary case that just completes
    issue(0, 0, 1, '0, TO, 32'h11111111, 0, 0);
    j = '0; j[15:0] = 16'h0200;
    issue(1, 0, 0, j, 0, 32'h0, 0, 0);
    issue(0, 0, 1, '0, TO - 1, 32'h22222222, 0, 0);
    issue(0, 1, 0, {6'd0, 32'hFFFF_FFF8}, TO, 32'h0, 0, 0);
    // Strobe while busy: flagged, write still completes; ocimem_a clears it
    j = '0; j[34:3] = 32'hA5A5A5A5;
    issue(0, 1, 0, j, 5, 32'h0, 1, 0);
    j = '0; j[15:0] = 16'h0040;
    issue(1, 0, 0, j, 0, 32'h0, 0, 0);
    // Word address wrap
    j = '0; j[34] = 1'b1; j[15:0] = 16'hFFFC;
    issue(1, 0, 0, j, 1, 32'h33333333, 0, 0);
    issue(0, 0, 1, '0, 0, 32'h44444444, 0, 0);
    // Coincident strobes resolved by priority
    j = '0; j[34] = 1'b1; j[15:0] = 16'h0100;
    issue(1, 1, 1, j, 0, 32'h55555555, 0, 0);
    j = '0; j[34:3] = 32'h0BADCAFE;
    issue(0, 1, 1, j, 2, 32'h0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      j = {6'($urandom), 32'($urandom)};
      r = $urandom_range(0, 9);
      wn = (r < 6) ? r % 4 : (r == 6) ? TO - 1 : (r == 7) ? TO : (r == 8) ? TO + 2 : 1;
      a = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      n = ($urandom_range(0, 1) == 0);
      if (!a && !b && !n) n = 1'b1;
      issue(a, b, n, j, wn, $urandom, ($urandom_range(0, 5) == 0), 0);
    end

    // Reset in the middle of a stalled read; strobe during reset is discarded
    @(posedge clk); #1;
    wait_n = 100;
    bus_q.push_back('{1'b0, {m_addr, 2'b00}, 32'h0, 4});
    sn = 1'b1;
    @(posedge clk); #1;
    sn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_read", {63'd0, avm_read}, 64'd0);
    chk("rst_mid_mondreg", {32'd0, MonDReg}, 64'd0);
    chk("rst_mid_ready", {63'd0, monitor_ready}, 64'd0);
    chk("rst_mid_error", {63'd0, monitor_error}, 64'd0);
    chk("rst_mid_addr", {48'd0, avm_address}, 64'd0);
    chk("rst_mid_wdata", {32'd0, avm_writedata}, 64'd0);
    j = '0; j[34] = 1'b1; j[15:0] = 16'h0100;
    jdo = j; sa = 1'b1;
    @(posedge clk); #1;
    sa = 1'b0; reset = 1'b0;
    chk("rst_strobe_drop", {63'd0, avm_read}, 64'd0);
    m_addr = '0; m_mdr = '0; m_err = 1'b0;
    wait_n = 0;
    issue(0, 0, 1, '0, 0, 32'h66666666, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    chk("comp_queue_empty", 64'(comp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
